// File: rtl/regbank_scan_top.sv
// regbank_scan_top: register bank with two registered read ports, one write port, and a
// multiplexed 7-segment scanner that shows both read results and both read addresses.
//
// Parameters:
//   DATA_W      register width, multiple of 4 from 4 to 16
//   ADDR_W      address width, 2**ADDR_W registers
//   REFRESH_DIV clk cycles per display digit slot, at least 2
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   addrRa    read address, port A
//   addrRb    read address, port B
//   addrW     write address
//   datW      write data
//   RegWrite  write enable
//   datOutRa  registered read data, port A
//   datOutRb  registered read data, port B
//   sseg      segments a..g, active low (sseg[0] = a)
//   an        digit enables, active low, one-hot-zero
//
// Configuration macro: WRITE_FWD_EN
//   defined   -> a read colliding with a same-cycle write returns the new data (write-first)
//   undefined -> the colliding read returns the old register content (read-first)
//
// Digit map: digits 0..NIB-1 are datOutRa nibbles (LS first), NIB..2*NIB-1 are datOutRb
// nibbles, 2*NIB is addrRa and 2*NIB+1 is addrRb (low 4 bits, zero-extended).

module regbank_scan_top #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrRa,
  input  logic [ADDR_W-1:0] addrRb,
  input  logic [ADDR_W-1:0] addrW,
  input  logic [DATA_W-1:0] datW,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] datOutRa,
  output logic [DATA_W-1:0] datOutRb,
  output logic [0:6]        sseg,
  output logic [2*(DATA_W/4)+1:0] an
);

  localparam int unsigned NIB   = DATA_W / 4;
  localparam int unsigned NDIG  = 2 * NIB + 2;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned DIG_W = $clog2(NDIG);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned AW4   = (ADDR_W < 4) ? ADDR_W : 4;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] rd_a_q, rd_b_q;
  logic [DATA_W-1:0] rd_a_d, rd_b_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DIG_W-1:0]  dig_q;
  logic [NDIG-1:0]   an_q;
  logic [0:6]        sseg_q;
  logic [3:0]        ra_nib, rb_nib;
  logic [3:0]        nib_val;

  // Low 4 address bits, zero-extended when the address is narrower.
  assign ra_nib = 4'(addrRa[AW4-1:0]);
  assign rb_nib = 4'(addrRb[AW4-1:0]);

  function automatic logic [0:6] seg_decode(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Read data next-state, with optional write-first forwarding on address collision.
  always_comb begin
    rd_a_d = regs_q[addrRa];
    rd_b_d = regs_q[addrRb];
`ifdef WRITE_FWD_EN
    if (RegWrite && (addrW == addrRa)) rd_a_d = datW;
    if (RegWrite && (addrW == addrRb)) rd_b_d = datW;
`endif
  end

  // Nibble selected by the current digit index.
  always_comb begin
    nib_val = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (dig_q == DIG_W'(i))       nib_val = rd_a_q[4*i +: 4];
      if (dig_q == DIG_W'(NIB + i)) nib_val = rd_b_q[4*i +: 4];
    end
    if (dig_q == DIG_W'(2 * NIB))     nib_val = ra_nib;
    if (dig_q == DIG_W'(2 * NIB + 1)) nib_val = rb_nib;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
      cnt_q  <= '0;
      dig_q  <= '0;
      an_q   <= '1;
      sseg_q <= 7'b1111111;
    end else begin
      if (RegWrite) regs_q[addrW] <= datW;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_q <= '0;
        dig_q <= (dig_q == DIG_W'(NDIG - 1)) ? '0 : dig_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Display lags the digit index and sources by one cycle.
      an_q   <= ~(NDIG'(1) << dig_q);
      sseg_q <= seg_decode(nib_val);
    end
  end

  assign datOutRa = rd_a_q;
  assign datOutRb = rd_b_q;
  assign an       = an_q;
  assign sseg     = sseg_q;

endmodule

// File: tb/tb_regbank_scan_top.sv
module tb_regbank_scan_top;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DIV    = 4;
  localparam int NIB    = DATA_W / 4;
  localparam int NDIG   = 2 * NIB + 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr_ra, addr_rb, addr_w;
  logic [DATA_W-1:0] dat_w;
  logic              reg_write;
  logic [DATA_W-1:0] dat_out_ra, dat_out_rb;
  logic [0:6]        sseg;
  logic [NDIG-1:0]   an;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_a, exp_b;
  logic [NDIG-1:0]   exp_an;
  logic [6:0]        exp_sseg;
  int                n_edges;
  logic [6:0]        glyph [16];

  always #5 clk = ~clk;

  regbank_scan_top #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addrRa  (addr_ra),
    .addrRb  (addr_rb),
    .addrW   (addr_w),
    .datW    (dat_w),
    .RegWrite(reg_write),
    .datOutRa(dat_out_ra),
    .datOutRb(dat_out_rb),
    .sseg    (sseg),
    .an      (an)
  );

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic step();
    int digit;
    int nib;
    logic [DATA_W-1:0] na, nb;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      exp_a    = '0;
      exp_b    = '0;
      exp_an   = '1;
      exp_sseg = 7'b1111111;
      n_edges  = 0;
    end else begin
      digit = (n_edges / DIV) % NDIG;
      if (digit < NIB)            nib = (int'(exp_a) >> (4 * digit)) & 15;
      else if (digit < 2 * NIB)   nib = (int'(exp_b) >> (4 * (digit - NIB))) & 15;
      else if (digit == 2 * NIB)  nib = int'(addr_ra) & 15;
      else                        nib = int'(addr_rb) & 15;
      exp_an   = ~(NDIG'(1) << digit);
      exp_sseg = glyph[nib];
      na = mem[addr_ra];
      nb = mem[addr_rb];
`ifdef WRITE_FWD_EN
      if (reg_write && addr_w == addr_ra) na = dat_w;
      if (reg_write && addr_w == addr_rb) nb = dat_w;
`endif
      exp_a = na;
      exp_b = nb;
      if (reg_write) mem[addr_w] = dat_w;
      n_edges++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reg_write = 1'b1;
      addr_w    = ADDR_W'($urandom);
      dat_w     = DATA_W'($urandom);
      addr_ra   = addr_w;
      addr_rb   = addr_w;
      step();
      checks++;
      if (an !== '1 || sseg !== 7'b1111111) begin
        errors++;
        $display("FAIL reset_display an=%b sseg=%b required an=%b sseg=1111111", an, sseg,
                 {NDIG{1'b1}});
      end
      checks++;
      if (dat_out_ra !== '0 || dat_out_rb !== '0) begin
        errors++;
        $display("FAIL reset_read a=%h b=%h required 0", dat_out_ra, dat_out_rb);
      end
    end
    rst = 1'b0;
    reg_write = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_ra = ADDR_W'(i);
      addr_rb = ADDR_W'(DEPTH - 1 - i);
      step();
      checks++;
      if (dat_out_ra !== '0 || dat_out_rb !== '0) begin
        errors++;
        $display("FAIL reset_contents i=%0d a=%h b=%h required 0", i, dat_out_ra, dat_out_rb);
      end
    end
  endtask

  task automatic test_write_read();
    reg_write = 1'b1;
    addr_w = 5; dat_w = 8'h09; step();
    addr_w = 2; dat_w = 8'h0C; step();
    reg_write = 1'b0;
    addr_ra = 5; addr_rb = 2;
    step();
    checks++;
    if (dat_out_ra !== 8'h09 || dat_out_rb !== 8'h0C) begin
      errors++;
      $display("FAIL write_read a=%h b=%h required a=09 b=0c", dat_out_ra, dat_out_rb);
    end
    addr_ra = 2; addr_rb = 2;
    step();
    checks++;
    if (dat_out_ra !== 8'h0C || dat_out_rb !== 8'h0C) begin
      errors++;
      $display("FAIL same_addr a=%h b=%h required 0c", dat_out_ra, dat_out_rb);
    end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] want;
    reg_write = 1'b1; addr_w = 3; dat_w = 8'h01; step();
    addr_w = 3; dat_w = 8'h07; addr_ra = 3; addr_rb = 3;
    step();
    reg_write = 1'b0;
`ifdef WRITE_FWD_EN
    want = 8'h07;
`else
    want = 8'h01;
`endif
    checks++;
    if (dat_out_ra !== want || dat_out_rb !== want) begin
      errors++;
      $display("FAIL collision a=%h b=%h required %h", dat_out_ra, dat_out_rb, want);
    end
    step();
    checks++;
    if (dat_out_ra !== 8'h07) begin
      errors++;
      $display("FAIL collision_after a=%h required 07", dat_out_ra);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reg_write = 1'($urandom);
      addr_w    = ADDR_W'($urandom);
      dat_w     = DATA_W'($urandom);
      addr_ra   = ($urandom_range(0, 3) == 0) ? addr_w : ADDR_W'($urandom);
      addr_rb   = ($urandom_range(0, 3) == 0) ? addr_ra : ADDR_W'($urandom);
      step();
      checks++;
      if (dat_out_ra !== exp_a || dat_out_rb !== exp_b) begin
        errors++;
        $display("FAIL rand_read cyc=%0d a=%h b=%h required a=%h b=%h", i, dat_out_ra,
                 dat_out_rb, exp_a, exp_b);
      end
      checks++;
      if (an !== exp_an || sseg !== exp_sseg) begin
        errors++;
        $display("FAIL rand_scan cyc=%0d an=%b sseg=%b required an=%b sseg=%b", i, an, sseg,
                 exp_an, exp_sseg);
      end
    end
    reg_write = 1'b0;
  endtask

  task automatic test_a5();
    bit seen0 = 0;
    bit seen1 = 0;
    reg_write = 1'b1; addr_w = 15; dat_w = 8'hA5; step();
    reg_write = 1'b0; addr_ra = 15; step();
    checks++;
    if (dat_out_ra !== 8'hA5) begin
      errors++;
      $display("FAIL a5_read a=%h required a5", dat_out_ra);
    end
    for (int i = 0; i < 2 * NDIG * DIV; i++) begin
      step();
      if (an == 6'b111110 && !seen0) begin
        seen0 = 1;
        checks++;
        if (sseg !== 7'b0100100) begin
          errors++;
          $display("FAIL a5_digit0 sseg=%b required 0100100", sseg);
        end
      end
      if (an == 6'b111101 && !seen1) begin
        seen1 = 1;
        checks++;
        if (sseg !== 7'b0001000) begin
          errors++;
          $display("FAIL a5_digit1 sseg=%b required 0001000", sseg);
        end
      end
    end
    checks++;
    if (!(seen0 && seen1)) begin
      errors++;
      $display("FAIL a5_timeout seen0=%0d seen1=%0d required 1 1", seen0, seen1);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    for (int i = 0; i < 2 * NDIG * DIV && !found; i++) begin
      step();
      if (an == 6'b111011) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_wait an=%b required 111011 within budget", an);
    end
    rst = 1'b1;
    step();
    checks++;
    if (an !== 6'b111111) begin
      errors++;
      $display("FAIL midrst_an an=%b required 111111", an);
    end
    rst = 1'b0;
    for (int i = 0; i < DIV; i++) begin
      step();
      checks++;
      if (an !== 6'b111110 || an !== exp_an) begin
        errors++;
        $display("FAIL midrst_restart cyc=%0d an=%b required 111110", i, an);
      end
    end
    step();
    checks++;
    if (an !== 6'b111101) begin
      errors++;
      $display("FAIL midrst_next an=%b required 111101", an);
    end
  endtask

  initial begin
    glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010;
    glyph[3]  = 7'b0000110; glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
    glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111; glyph[8]  = 7'b0000000;
    glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
    glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000;
    glyph[15] = 7'b0111000;
    rst = 1'b1; reg_write = 1'b0;
    addr_ra = '0; addr_rb = '0; addr_w = '0; dat_w = '0;
    n_edges = 0;
    test_reset();
    test_write_read();
    test_collision();
    test_random();
    test_a5();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_scan_top.md
REGBANK_SCAN_TOP -- requirements
Module: regbank_scan_top

Interface
REQ-001 SHALL have parameter DATA_W, default 4, register width in bits; legal values are multiples of 4 from 4 to 16.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per display digit slot; minimum 2.
REQ-004 SHALL derive localparams NIB = DATA_W/4 and NDIG = 2*NIB + 2.
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 addrRa  input  ADDR_W  read address, port A.
REQ-008 addrRb  input  ADDR_W  read address, port B.
REQ-009 addrW  input  ADDR_W  write address.
REQ-010 datW  input  DATA_W  write data.
REQ-011 RegWrite  input  1  write enable.
REQ-012 datOutRa  output  DATA_W  registered read data, port A.
REQ-013 datOutRb  output  DATA_W  registered read data, port B.
REQ-014 sseg  output  [0:6]  segments a..g, active low.
REQ-015 an  output  NDIG  digit enables, active low, one-hot-zero.

Function
REQ-016 Write: on a clk edge with RegWrite=1 and rst=0, reg[addrW] SHALL take datW; with RegWrite=0 no register changes.
REQ-017 Read: on every clk edge with rst=0, datOutRa SHALL take reg[addrRa] and datOutRb SHALL take reg[addrRb]; latency 1 cycle.
REQ-018 Both ports SHALL be independent; addrRa==addrRb SHALL return identical data on both ports.
REQ-019 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; on the wrap cycle the digit index SHALL advance by 1, wrapping from NDIG-1 to 0.
REQ-020 Digit map: digits 0..NIB-1 = nibbles of datOutRa (LS first); digits NIB..2*NIB-1 = nibbles of datOutRb (LS first); digit 2*NIB = addrRa zero-extended to 4 bits; digit 2*NIB+1 = addrRb zero-extended to 4 bits. When ADDR_W > 4, the low 4 address bits SHALL be shown.
REQ-021 an and sseg SHALL be registered: in each cycle they reflect the digit index and the display source values of the previous cycle; exactly one an bit SHALL be 0 outside reset.
REQ-022 Decoder SHALL map 0-F to the standard hex glyphs; examples: 0 -> 0000001, 8 -> 0000000, A -> 0001000, F -> 0111000.

Reset
REQ-023 While rst=1 on a clk edge, all registers, datOutRa, datOutRb, the prescaler and the digit index SHALL clear to 0; an SHALL be all 1s and sseg SHALL be 1111111.
REQ-024 Writes and reads in a reset cycle SHALL be ignored; reset SHALL take priority over RegWrite.
REQ-025 Reset mid-scan SHALL restart at digit 0; in the first cycle after rst falls, an SHALL be ~1 (digit 0 enabled).

Configuration
REQ-026 Macro WRITE_FWD_EN: when defined, a read on either port whose address equals addrW in a cycle with RegWrite=1 SHALL return datW at the next edge (write-first).
REQ-027 When WRITE_FWD_EN is undefined, the same collision SHALL return the old register content (read-first); the new data SHALL be visible from the following read.

Verification
REQ-028 Reset, then read all addresses on both ports -> datOutRa = datOutRb = 0 at every address; an = all 1s during reset.
REQ-029 Write reg[5]=0x9 and reg[2]=0xC; set addrRa=5, addrRb=2 -> one cycle later datOutRa=0x9 and datOutRb=0xC.
REQ-030 Collision: reg[3]=0x1; same cycle RegWrite=1, addrW=3, datW=0x7, addrRa=3 -> next cycle datOutRa=0x7 with WRITE_FWD_EN, 0x1 without.
REQ-031 Scan with REFRESH_DIV=4, DATA_W=4 (NDIG=4) -> each an pattern 1110, 1101, 1011, 0111 lasts 4 cycles, then the sequence repeats; sseg shows datOutRa, datOutRb, addrRa, addrRb.
REQ-032 DATA_W=8, ADDR_W=4: write reg[15]=0xA5; set addrRa=15 -> digit 0 sseg=0100100 (5) and digit 1 sseg=0001000 (A); an is 6 bits wide.
REQ-033 Assert rst while digit 2 is enabled -> an = all 1s on the next edge; after rst falls, scan restarts at digit 0 with the prescaler at 0.
